// File: rtl/mult_share_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mult_share_ctrl_pkg
//   Shared definitions for the multiplier-sharing controller: FSM state
//   encodings, default parameter values and the round-robin pointer helper.
// ----------------------------------------------------------------------------
package mult_share_ctrl_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_LENGTH  = 32;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_CW      = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOW  = 3'd1,
        ST_WAIT_HIGH = 3'd2,
        ST_ERR       = 3'd3,
        ST_FLUSH     = 3'd4
    } state_t;

    // Pointer value after serving requester g: the one just above it, wrapping.
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mult_share_ctrl_rr_arbiter
//   Combinational round-robin pick: the first set request bit at or above
//   ptr, wrapping to the lowest set bit when nothing at or above ptr is set.
//
// Ports
//   req      in   NREQ  request vector
//   ptr      in   IW    highest-priority requester index
//   gnt      out  NREQ  one-hot grant (all zero when no request)
//   gnt_idx  out  IW    binary index of the granted requester
//   any_req  out  1     at least one request bit is set
// ----------------------------------------------------------------------------
module mult_share_ctrl_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any_req
);

    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] src;

    // Requests at or above the pointer win; otherwise fall back to the full
    // vector, whose lowest set bit is then necessarily below the pointer.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
    end

    assign hi_req  = req & hi_mask;
    assign src     = (|hi_req) ? hi_req : req;
    assign any_req = |req;

    always_comb begin
        gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (src[i]) gnt_idx = IW'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = any_req && (gnt_idx == IW'(i));
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// ----------------------------------------------------------------------------
// mult_share_ctrl
//   Shares one iterative multiplier (start/ready handshake) among NREQ
//   requesters. Picks a requester round-robin, launches the multiplier,
//   follows ready falling then rising under a watchdog, and routes the
//   product (or an error response) back to the granted requester. After a
//   watchdog error it waits for the multiplier to go idle before accepting
//   new work, so a start never lands on a busy multiplier.
//
// Ports
//   clock       in   1           rising-edge clock
//   reset       in   1           asynchronous active-high reset
//   req         in   NREQ        per-requester request, held until req_ack
//   req_a       in   NREQ*LENGTH operand A, slice i for requester i
//   req_b       in   NREQ*LENGTH operand B, slice i for requester i
//   req_ack     out  NREQ        one-cycle one-hot: operands accepted
//   resp_valid  out  NREQ        one-cycle one-hot: response for requester i
//   resp_p      out  2*LENGTH    product, held until the next response
//   resp_err    out  1           qualifies resp_valid: watchdog fired, p = 0
//   busy        out  1           controller not idle
//   mul_start   out  1           start pulse to the multiplier
//   mul_a       out  LENGTH      operand A to the multiplier
//   mul_b       out  LENGTH      operand B to the multiplier
//   mul_ready   in   1           multiplier idle with P valid
//   mul_p       in   2*LENGTH    multiplier product
// ----------------------------------------------------------------------------
module mult_share_ctrl
    import mult_share_ctrl_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int LENGTH  = DEF_LENGTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CW      = DEF_CW
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*LENGTH-1:0] req_a,
    input  logic [NREQ*LENGTH-1:0] req_b,
    output logic [NREQ-1:0]        req_ack,
    output logic [NREQ-1:0]        resp_valid,
    output logic [2*LENGTH-1:0]    resp_p,
    output logic                   resp_err,
    output logic                   busy,
    output logic                   mul_start,
    output logic [LENGTH-1:0]      mul_a,
    output logic [LENGTH-1:0]      mul_b,
    input  logic                   mul_ready,
    input  logic [2*LENGTH-1:0]    mul_p
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t                     state_q, state_d;
    logic [IW-1:0]              ptr_q, ptr_d;
    logic [IW-1:0]              gidx_q, gidx_d;
    logic [CW-1:0]              wd_q, wd_d;
    logic [CW-1:0]              wd_inc;
    logic                       wd_hit;

    logic [NREQ-1:0]            req_ack_d;
    logic [NREQ-1:0]            resp_valid_d;
    logic [2*LENGTH-1:0]        resp_p_d;
    logic                       resp_err_d;
    logic                       busy_d;
    logic                       mul_start_d;
    logic [LENGTH-1:0]          mul_a_d, mul_b_d;

    // Packed views: element i is exactly slice i of the flattened buses.
    logic [NREQ-1:0][LENGTH-1:0] a_vec, b_vec;
    assign a_vec = req_a;
    assign b_vec = req_b;

    logic [NREQ-1:0]            arb_gnt;
    logic [IW-1:0]              arb_idx;
    logic                       arb_any;

    mult_share_ctrl_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any_req (arb_any)
    );

    // Watchdog saturates so it can never wrap back below TIMEOUT.
    assign wd_hit = (wd_q == CW'(TIMEOUT));
    assign wd_inc = (&wd_q) ? wd_q : wd_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gidx_d       = gidx_q;
        wd_d         = wd_q;
        mul_a_d      = mul_a;
        mul_b_d      = mul_b;
        mul_start_d  = 1'b0;
        req_ack_d    = '0;
        resp_valid_d = '0;
        resp_err_d   = 1'b0;
        resp_p_d     = resp_p;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gidx_d      = arb_idx;
                    mul_a_d     = a_vec[arb_idx];
                    mul_b_d     = b_vec[arb_idx];
                    req_ack_d   = arb_gnt;
                    mul_start_d = 1'b1;
                    ptr_d       = IW'(rr_next(int'(arb_idx), NREQ));
                    wd_d        = '0;
                    state_d     = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                // Ready falling is the multiplier acknowledging the start.
                if (!mul_ready) begin
                    wd_d    = '0;
                    state_d = ST_WAIT_HIGH;
                end else if (wd_hit) begin
                    state_d = ST_ERR;
                end else begin
                    wd_d = wd_inc;
                end
            end
            ST_WAIT_HIGH: begin
                if (mul_ready) begin
                    resp_p_d             = mul_p;
                    resp_valid_d[gidx_q] = 1'b1;
                    state_d              = ST_IDLE;
                end else if (wd_hit) begin
                    state_d = ST_ERR;
                end else begin
                    wd_d = wd_inc;
                end
            end
            ST_ERR: begin
                resp_valid_d[gidx_q] = 1'b1;
                resp_err_d           = 1'b1;
                resp_p_d             = '0;
                state_d              = ST_FLUSH;
            end
            ST_FLUSH: begin
                // No watchdog here: a multiplier that never recovers simply
                // keeps the controller parked rather than risking a start
                // into an operation still in progress.
                if (mul_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gidx_q     <= '0;
            wd_q       <= '0;
            req_ack    <= '0;
            resp_valid <= '0;
            resp_p     <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            wd_q       <= wd_d;
            req_ack    <= req_ack_d;
            resp_valid <= resp_valid_d;
            resp_p     <= resp_p_d;
            resp_err   <= resp_err_d;
            busy       <= busy_d;
            mul_start  <= mul_start_d;
            mul_a      <= mul_a_d;
            mul_b      <= mul_b_d;
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mult_share_ctrl
//   Directed plus randomized bench for mult_share_ctrl with a behavioural
//   multiplier (ready falls one cycle after start, stays low mm_lat cycles).
// ----------------------------------------------------------------------------
module tb_mult_share_ctrl;

    localparam int NREQ    = 4;
    localparam int LENGTH  = 32;
    localparam int TIMEOUT = 255;
    localparam int CW      = 8;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [NREQ-1:0]        req   = '0;
    logic [NREQ*LENGTH-1:0] req_a = '0;
    logic [NREQ*LENGTH-1:0] req_b = '0;
    logic [NREQ-1:0]        req_ack;
    logic [NREQ-1:0]        resp_valid;
    logic [2*LENGTH-1:0]    resp_p;
    logic                   resp_err;
    logic                   busy;
    logic                   mul_start;
    logic [LENGTH-1:0]      mul_a;
    logic [LENGTH-1:0]      mul_b;
    logic                   mul_ready = 1'b1;
    logic [2*LENGTH-1:0]    mul_p     = '0;

    mult_share_ctrl #(
        .NREQ(NREQ), .LENGTH(LENGTH), .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .req_ack(req_ack), .resp_valid(resp_valid), .resp_p(resp_p),
        .resp_err(resp_err), .busy(busy), .mul_start(mul_start),
        .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready), .mul_p(mul_p)
    );

    always #5 clock = ~clock;

    // Behavioural multiplier.
    int             mm_lat   = 34;
    bit             mm_stuck = 1'b0;
    int             mm_cnt   = 0;
    logic [63:0]    mm_res   = '0;

    always @(posedge clock) begin
        if (mm_cnt != 0) begin
            mm_cnt <= mm_cnt - 1;
            if (mm_cnt == 1) begin
                mul_ready <= 1'b1;
                mul_p     <= mm_res;
            end
        end else if (mul_start && mul_ready && !mm_stuck) begin
            mul_ready <= 1'b0;
            mm_res    <= 64'(mul_a) * 64'(mul_b);
            mm_cnt    <= mm_lat;
        end
    end

    typedef struct {
        logic [NREQ-1:0] v;
        logic [63:0]     p;
        logic            e;
        int              cyc;
    } rsp_t;

    rsp_t            rsp_q[$];
    logic [NREQ-1:0] ack_q[$];
    int              ack_cyc_q[$];
    logic [31:0]     op_a[NREQ];
    logic [31:0]     op_b[NREQ];
    int              checks    = 0;
    int              errors    = 0;
    int              cyc       = 0;
    int              pulse_bad = 0;
    int              bad_start = 0;
    int              mptr      = 0;
    bit              auto_drop = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; samples at the falling edge and acts as the requesters,
    // dropping a req bit once it has been acknowledged.
    task automatic step();
        @(negedge clock);
        cyc++;
        if ((req_ack != '0) != mul_start) pulse_bad++;
        if (!$onehot0(req_ack) || !$onehot0(resp_valid)) pulse_bad++;
        if (resp_err && resp_valid == '0) pulse_bad++;
        if (mul_start && !mul_ready) bad_start++;
        if (req_ack != '0) begin
            ack_q.push_back(req_ack);
            ack_cyc_q.push_back(cyc);
        end
        if (resp_valid != '0)
            rsp_q.push_back('{v: resp_valid, p: resp_p, e: resp_err, cyc: cyc});
        if (auto_drop) req = req & ~req_ack;
    endtask

    task automatic clr();
        ack_q.delete();
        ack_cyc_q.delete();
        rsp_q.delete();
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        op_a[i] = a;
        op_b[i] = b;
        req_a[i*LENGTH +: LENGTH] = a;
        req_b[i*LENGTH +: LENGTH] = b;
    endtask

    task automatic wait_rsp(input int n, input int budget, input string tag);
        int k = 0;
        while (rsp_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check({tag, "_rsp_count"}, 64'(rsp_q.size()), 64'(n));
    endtask

    // Reference arbitration: first pending requester at or after p, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Raise a set of requests together; each drops after its ack.
    task automatic burst(input logic [NREQ-1:0] mask, input string tag);
        int              order[$];
        logic [NREQ-1:0] m;
        logic [NREQ-1:0] oh;
        int              g;
        m = mask;
        clr();
        while (m != '0) begin
            g = rr_pick(m, mptr);
            order.push_back(g);
            m[g] = 1'b0;
            mptr = (g + 1) % NREQ;
        end
        auto_drop = 1'b1;
        req = mask;
        wait_rsp(order.size(), 60 * order.size() + 40, tag);
        for (int k = 0; k < order.size(); k++) begin
            oh = '0;
            oh[order[k]] = 1'b1;
            check($sformatf("%s_ack%0d", tag, k), 64'(ack_q[k]), 64'(oh));
            check($sformatf("%s_rv%0d", tag, k), 64'(rsp_q[k].v), 64'(oh));
            check($sformatf("%s_p%0d", tag, k), rsp_q[k].p,
                  64'(op_a[order[k]]) * 64'(op_b[order[k]]));
            check($sformatf("%s_err%0d", tag, k), 64'(rsp_q[k].e), 64'(0));
        end
    endtask

    initial begin
        int ord_exp[5];
        int p_exp[5];
        int k;
        int flush_idle;
        ord_exp = '{0, 1, 2, 3, 0};
        p_exp   = '{2, 6, 12, 20, 2};
        for (int i = 0; i < NREQ; i++) set_ops(i, 32'd0, 32'd0);

        // Reset state.
        #1 reset = 1'b1;
        #2;
        check("rst_req_ack", 64'(req_ack), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_mul_start", 64'(mul_start), 64'(0));
        check("rst_resp_p", resp_p, 64'(0));
        check("rst_mul_ab", {mul_a, mul_b}, 64'(0));
        step();
        step();
        reset = 1'b0;
        mptr = 0;

        // Contention: all four held continuously.
        clr();
        for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i + 1), 32'(i + 2));
        auto_drop = 1'b0;
        req = 4'b1111;
        wait_rsp(5, 400, "cont");
        req = '0;
        step();
        step();
        check("cont_ack_count", 64'(ack_q.size()), 64'(5));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("cont_ack%0d", i), 64'(ack_q[i]), 64'(1) << ord_exp[i]);
            check($sformatf("cont_rv%0d", i), 64'(rsp_q[i].v), 64'(1) << ord_exp[i]);
            check($sformatf("cont_p%0d", i), rsp_q[i].p, 64'(p_exp[i]));
        end
        mptr = 1;
        auto_drop = 1'b1;

        // Single request with latency checks.
        clr();
        mm_lat = 34;
        set_ops(0, 32'h0000F0F0, 32'h0000FF00);
        req = 4'b0001;
        k = cyc;
        wait_rsp(1, 200, "single");
        check("single_ack", 64'(ack_q[0]), 64'(1));
        check("single_ack_lat", 64'(ack_cyc_q[0] - k), 64'(1));
        check("single_ack_count", 64'(ack_q.size()), 64'(1));
        check("single_rv", 64'(rsp_q[0].v), 64'(1));
        check("single_p", rsp_q[0].p, 64'h00000000EFFF1000);
        check("single_err", 64'(rsp_q[0].e), 64'(0));
        check("single_rsp_lat", 64'(rsp_q[0].cyc - ack_cyc_q[0]), 64'(mm_lat + 2));
        mptr = 1;

        // Pointer wrap: serve 2 alone, then 0 and 2 together.
        set_ops(2, $urandom(), $urandom());
        burst(4'b0100, "wrap_a");
        set_ops(0, $urandom(), $urandom());
        set_ops(2, $urandom(), $urandom());
        burst(4'b0101, "wrap_b");
        check("wrap_first_is_0", 64'(ack_q[0]), 64'(4'b0001));

        // Watchdog: ready stays low for 300 cycles.
        clr();
        mm_lat = 300;
        set_ops(0, $urandom(), $urandom());
        req = 4'b0001;
        wait_rsp(1, 400, "wd");
        check("wd_rv", 64'(rsp_q[0].v), 64'(1));
        check("wd_err", 64'(rsp_q[0].e), 64'(1));
        check("wd_p", rsp_q[0].p, 64'(0));
        check("wd_lat", 64'(rsp_q[0].cyc - ack_cyc_q[0]), 64'(TIMEOUT + 4));
        check("wd_busy_flush", 64'(busy), 64'(1));
        mm_lat = 34;
        set_ops(1, $urandom(), $urandom());
        req = 4'b0010;
        k = 0;
        flush_idle = 0;
        while (!mul_ready && k < 200) begin
            step();
            k++;
            if (!busy && !mul_ready) flush_idle++;
        end
        check("wd_ready_rose", 64'(mul_ready), 64'(1));
        check("wd_no_ack_in_flush", 64'(ack_q.size()), 64'(1));
        check("wd_flush_busy", 64'(flush_idle), 64'(0));
        wait_rsp(2, 200, "wd_next");
        check("wd_next_ack", 64'(ack_q[1]), 64'(4'b0010));
        check("wd_next_p", rsp_q[1].p, 64'(op_a[1]) * 64'(op_b[1]));
        check("wd_next_err", 64'(rsp_q[1].e), 64'(0));
        mptr = 2;

        // Stuck-ready: multiplier ignores the start.
        clr();
        mm_stuck = 1'b1;
        set_ops(2, $urandom(), $urandom());
        req = 4'b0100;
        wait_rsp(1, 400, "stuck");
        check("stuck_rv", 64'(rsp_q[0].v), 64'(4'b0100));
        check("stuck_err", 64'(rsp_q[0].e), 64'(1));
        check("stuck_p", rsp_q[0].p, 64'(0));
        check("stuck_lat", 64'(rsp_q[0].cyc - ack_cyc_q[0]), 64'(TIMEOUT + 2));
        step();
        check("stuck_flush_exit", 64'(busy), 64'(0));
        mm_stuck = 1'b0;
        mptr = 3;

        // Randomized bursts against the reference arbitration.
        for (int b = 0; b < 12; b++) begin
            logic [NREQ-1:0] mask;
            mask = NREQ'($urandom_range(15, 1));
            mm_lat = $urandom_range(40, 1);
            for (int i = 0; i < NREQ; i++) set_ops(i, $urandom(), $urandom());
            burst(mask, $sformatf("rnd%0d", b));
        end

        // Reset mid-operation (WAIT_HIGH).
        clr();
        mm_lat = 34;
        set_ops(1, $urandom(), $urandom());
        req = 4'b0010;
        k = 0;
        while (ack_q.size() == 0 && k < 20) begin
            step();
            k++;
        end
        check("mid_ack", 64'(ack_q.size()), 64'(1));
        for (int i = 0; i < 4; i++) step();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_outputs", 64'({req_ack, resp_valid, resp_err, mul_start}), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_resp_p", resp_p, 64'(0));
        check("mid_rst_mul_ab", {mul_a, mul_b}, 64'(0));
        step();
        step();
        reset = 1'b0;
        mptr = 0;
        clr();
        for (int i = 0; i < 45; i++) step();
        check("mid_no_rsp", 64'(rsp_q.size()), 64'(0));
        check("mid_no_ack", 64'(ack_q.size()), 64'(0));
        set_ops(0, $urandom(), $urandom());
        set_ops(3, $urandom(), $urandom());
        burst(4'b1001, "post_rst");

        check("start_to_busy_mul", 64'(bad_start), 64'(0));
        check("pulse_shape", 64'(pulse_bad), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
